fft_butterfly_sequencer: RTL and testbench
==========================================

// Module: fft_butterfly_sequencer
// PURPOSE
//  In-place radix-2 DIT FFT controller that sits directly upstream of butterfly_sum.
//  It buffers N complex samples in bit-reversed order and, each cycle, feeds one operand
//  pair (A,B) plus a twiddle index to the butterfly, writing its C/D results back in place.
//  When all stages finish, it streams the N results out in natural order.
// PARAMETERS
//  N_POINTS  8   transform length, power of two, >=4
//  LOG2_N    3   log2(N_POINTS), equals the stage count
//  WORD_SZ   32  complex word, {real[31:16], imag[15:0]}
// PORTS
//  i_clk           in   1         clock; all logic on rising edge
//  i_rst           in   1         synchronous reset, active-high
//  i_sample        in   WORD_SZ   input sample
//  i_sample_valid  in   1         i_sample valid
//  o_sample_ready  out  1         sequencer accepts a sample (state LOAD)
//  o_A             out  WORD_SZ   butterfly upper operand (to butterfly i_A)
//  o_B             out  WORD_SZ   butterfly lower operand (to butterfly i_B)
//  o_tw_idx        out  LOG2_N-1  twiddle ROM index; ROM drives butterfly i_twiddleA/B
//  o_bf_valid      out  1         o_A/o_B/o_tw_idx valid this cycle
//  i_C             in   WORD_SZ   butterfly result, written to slot idxA
//  i_D             in   WORD_SZ   butterfly result, written to slot idxB
//  o_result        out  WORD_SZ   output sample, natural order
//  o_result_valid  out  1         o_result valid
//  i_result_ready  in   1         downstream accepts o_result
//  o_busy          out  1         high in COMPUTE or UNLOAD
//  o_done          out  1         one-cycle pulse on the final result transfer
// BEHAVIOUR
//  - Reset: state=LOAD, all counters=0; o_sample_ready=1; all other outputs=0.
//    Buffer contents are not cleared. Reset takes priority in every state, including mid-op.
//  - Storage: N x WORD_SZ register array mem[].
//  - FSM: LOAD -> COMPUTE -> UNLOAD -> LOAD. No idle state.
//  - LOAD: o_sample_ready=1. On i_sample_valid, sample k (k=0..N-1) is written to
//    mem[bitrev(k)] and k increments. The N-th accept moves to COMPUTE on the next edge.
//  - COMPUTE: one butterfly per cycle, N/2*LOG2_N cycles total, o_bf_valid=1.
//    For stage s (0..LOG2_N-1) and butterfly b (0..N/2-1): half=2^s, pos=b&(half-1);
//    idxA=((b>>s)<<(s+1))+pos; idxB=idxA+half; o_tw_idx=pos<<(LOG2_N-1-s).
//    o_A=mem[idxA] and o_B=mem[idxB] are combinational from registered counters.
//    On the edge: mem[idxA]<=i_C, mem[idxB]<=i_D (butterfly is combinational, zero latency).
//    b wraps to 0 and s increments; after the last b of the last s, move to UNLOAD.
//  - Outside COMPUTE, o_A/o_B/o_tw_idx are driven 0 and o_bf_valid=0.
//  - UNLOAD: o_result=mem[j], o_result_valid=1, j=0..N-1.
//    j advances only when valid&&ready. o_result is held stable while stalled.
//    The transfer of j=N-1 pulses o_done and returns to LOAD with counters at 0.
//  - o_sample_ready=0 outside LOAD. i_sample_valid is ignored outside LOAD.
//  - Latency: the first o_result_valid comes N/2*LOG2_N+1 cycles after the edge
//    that accepts the last sample.
//  - Arithmetic: none in this block; words are moved unmodified. All counters wrap explicitly.
// TESTING (N=8; bench butterfly stub C=A+B, D=A-B per 16-bit half unless stated)
//  1 DC: 8 x 32'h0001_0000 -> results 32'h0008_0000 then 7 x 32'h0000_0000, then o_done pulse.
//  2 Order: pass-through stub (C=A,D=B), sample k=32'h0000_000k -> first COMPUTE cycle
//    o_A=0, o_B=4; stage 2 o_tw_idx sequence 0,1,2,3; stage 1 sequence 0,2,0,2.
//  3 Backpressure: i_result_ready toggles 1,0,0,1,... -> 8 results, each exactly once,
//    in order, o_result constant while stalled.
//  4 Input gaps: i_sample_valid low on alternate cycles -> 8 accepts, then o_sample_ready=0;
//    the 9th word is not taken until after o_done.
//  5 Reset mid-COMPUTE (stage 1): next cycle o_sample_ready=1, o_bf_valid=0, o_busy=0;
//    re-running test 1 passes.
//  6 Timing: exactly 12 cycles with o_bf_valid=1; o_result_valid first high 13 cycles
//    after the last accept edge.

Source files
------------

// File: rtl/fft_butterfly_sequencer.sv
// In-place radix-2 DIT FFT operand sequencer feeding butterfly_sum.
// Loads N samples in bit-reversed order, runs every butterfly stage, then unloads in natural order.
module fft_butterfly_sequencer #(
    parameter int N_POINTS = 8,
    parameter int LOG2_N   = 3,
    parameter int WORD_SZ  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WORD_SZ-1:0]   i_sample,
    input  logic                 i_sample_valid,
    output logic                 o_sample_ready,
    output logic [WORD_SZ-1:0]   o_A,
    output logic [WORD_SZ-1:0]   o_B,
    output logic [LOG2_N-2:0]    o_tw_idx,
    output logic                 o_bf_valid,
    input  logic [WORD_SZ-1:0]   i_C,
    input  logic [WORD_SZ-1:0]   i_D,
    output logic [WORD_SZ-1:0]   o_result,
    output logic                 o_result_valid,
    input  logic                 i_result_ready,
    output logic                 o_busy,
    output logic                 o_done
);
    // state   | meaning
    // LOAD    | accepting samples into mem[bitrev(k)]
    // COMPUTE | one butterfly per cycle, C/D written back in place
    // UNLOAD  | streaming mem[0..N-1] downstream under ready/valid
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    localparam int SW = $clog2(LOG2_N);
    localparam int BW = LOG2_N - 1;

    state_t              state, state_nxt;
    logic [LOG2_N-1:0]   load_cnt;
    logic [LOG2_N-1:0]   unload_cnt;
    logic [BW-1:0]       bf_cnt;
    logic [SW-1:0]       stage_cnt;
    logic [WORD_SZ-1:0]  mem [N_POINTS];

    logic [LOG2_N-1:0]   half, pos, idx_a, idx_b;
    logic                sample_acc, result_acc;
    logic                load_last, compute_last, unload_last;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2_N; i++) r[i] = v[LOG2_N-1-i];
        return r;
    endfunction

    // Butterfly b of stage s pairs slot idxA with idxA+2^s; twiddle step scales with stage.
    always_comb begin
        half  = LOG2_N'(1) << stage_cnt;
        pos   = {1'b0, bf_cnt} & (half - LOG2_N'(1));
        idx_a = (({1'b0, bf_cnt} >> stage_cnt) << ({1'b0, stage_cnt} + (SW+1)'(1))) | pos;
        idx_b = idx_a | half;
    end

    assign sample_acc   = (state == LOAD) && i_sample_valid;
    assign result_acc   = (state == UNLOAD) && i_result_ready;
    assign load_last    = (load_cnt == LOG2_N'(N_POINTS-1));
    assign unload_last  = (unload_cnt == LOG2_N'(N_POINTS-1));
    assign compute_last = (stage_cnt == SW'(LOG2_N-1)) && (bf_cnt == {BW{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (sample_acc && load_last)   state_nxt = COMPUTE;
            COMPUTE: if (compute_last)              state_nxt = UNLOAD;
            UNLOAD:  if (result_acc && unload_last) state_nxt = LOAD;
            default:                                state_nxt = LOAD;
        endcase
    end

    always_comb begin
        o_sample_ready = 1'b0;
        o_A            = '0;
        o_B            = '0;
        o_tw_idx       = '0;
        o_bf_valid     = 1'b0;
        o_result       = '0;
        o_result_valid = 1'b0;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        unique case (state)
            LOAD: o_sample_ready = 1'b1;
            COMPUTE: begin
                o_A        = mem[idx_a];
                o_B        = mem[idx_b];
                o_tw_idx   = BW'(pos << (BW - int'(stage_cnt)));
                o_bf_valid = 1'b1;
                o_busy     = 1'b1;
            end
            UNLOAD: begin
                o_result       = mem[unload_cnt];
                o_result_valid = 1'b1;
                o_busy         = 1'b1;
                o_done         = i_result_ready && unload_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            load_cnt   <= '0;
            unload_cnt <= '0;
            bf_cnt     <= '0;
            stage_cnt  <= '0;
        end else begin
            if (sample_acc)
                load_cnt <= load_last ? '0 : load_cnt + LOG2_N'(1);
            if (state == COMPUTE) begin
                bf_cnt <= bf_cnt + BW'(1);
                if (bf_cnt == {BW{1'b1}})
                    stage_cnt <= compute_last ? '0 : stage_cnt + SW'(1);
            end
            if (result_acc)
                unload_cnt <= unload_last ? '0 : unload_cnt + LOG2_N'(1);
        end
    end

    // Buffer is deliberately not cleared by reset; reset only blocks writes.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (sample_acc) begin
                mem[bitrev(load_cnt)] <= i_sample;
            end else if (state == COMPUTE) begin
                mem[idx_a] <= i_C;
                mem[idx_b] <= i_D;
            end
        end
    end
endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Scoreboard bench: a Walsh/bit-reversal reference model predicts results; a negedge monitor checks them.
module tb_fft_butterfly_sequencer;
    localparam int N = 8;
    localparam int L = 3;
    typedef logic [31:0] frame_t [N];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] a, b, c, d;
    logic [1:0]  tw_idx;
    logic        bf_valid;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    fft_butterfly_sequencer #(.N_POINTS(N), .LOG2_N(L), .WORD_SZ(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_sample(sample), .i_sample_valid(sample_valid), .o_sample_ready(sample_ready),
        .o_A(a), .o_B(b), .o_tw_idx(tw_idx), .o_bf_valid(bf_valid),
        .i_C(c), .i_D(d),
        .o_result(result), .o_result_valid(result_valid), .i_result_ready(result_ready),
        .o_busy(busy), .o_done(done)
    );

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];
    bit          pass_mode = 1'b0;
    int          bp_mode = 0;
    int          bp_phase = 0;
    int          rcount = 0;
    int          frames_out = 0;
    int          bf_seen = 0;
    logic [1:0]  tw_log[$];
    logic [31:0] a_log[$];
    logic [31:0] b_log[$];
    bit          stall_pending = 1'b0;
    logic [31:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int i = 0; i < L; i++) if (v[i]) r |= (1 << (L-1-i));
        return r;
    endfunction

    // With a sum/difference butterfly and no twiddles, the DIT network computes
    // X[j] = sum_k x[k] * (-1)^popcount(j & bitrev(k)) on each 16-bit half.
    function automatic frame_t model(input frame_t x, input bit pass);
        frame_t      y;
        logic [15:0] re, im;
        for (int j = 0; j < N; j++) begin
            if (pass) begin
                y[j] = x[brev(j)];
            end else begin
                re = '0;
                im = '0;
                for (int k = 0; k < N; k++) begin
                    if ($countones(j & brev(k)) % 2 == 1) begin
                        re = re - x[k][31:16];
                        im = im - x[k][15:0];
                    end else begin
                        re = re + x[k][31:16];
                        im = im + x[k][15:0];
                    end
                end
                y[j] = {re, im};
            end
        end
        return y;
    endfunction

    always_comb begin
        if (pass_mode) begin
            c = a;
            d = b;
        end else begin
            c = {a[31:16] + b[31:16], a[15:0] + b[15:0]};
            d = {a[31:16] - b[31:16], a[15:0] - b[15:0]};
        end
    end

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1: begin
                result_ready = (bp_phase == 0);
                bp_phase = (bp_phase == 2) ? 0 : bp_phase + 1;
            end
            2:       result_ready = 1'($urandom_range(0, 1));
            default: result_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (bf_valid) begin
                tw_log.push_back(tw_idx);
                a_log.push_back(a);
                b_log.push_back(b);
                bf_seen++;
            end
            if (busy) chk("ready_low_while_busy", 32'(sample_ready), 0);
            if (stall_pending && result_valid) chk("stall_hold", result, held);
            stall_pending = result_valid && !result_ready;
            held = result;
            chk("done_pulse", 32'(done), 32'(result_valid && result_ready && rcount == N-1));
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(result_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e);
                end
                rcount = (rcount + 1) % N;
                if (rcount == 0) frames_out++;
            end
        end else begin
            rcount = 0;
            stall_pending = 1'b0;
        end
    end

    task automatic load_frame(input frame_t x, input bit gaps);
        int k = 0;
        int guard = 0;
        bit tog = 1'b0;
        bit acc;
        while (k < N && guard < 200) begin
            sample = x[k];
            sample_valid = gaps ? tog : 1'b1;
            tog = ~tog;
            @(negedge clk);
            acc = sample_valid && sample_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        sample_valid = 1'b0;
        chk("load_complete", k, N);
    endtask

    // hold9 leaves a ninth word (w9) asserted through COMPUTE/UNLOAD.
    task automatic run_frame(input frame_t x, input bit pass, input bit gaps,
                             input bit hold9, input logic [31:0] w9);
        frame_t y;
        int     lat = 0;
        int     guard = 0;
        int     start = frames_out;
        int     bf_base = bf_seen;
        pass_mode = pass;
        y = model(x, pass);
        for (int j = 0; j < N; j++) exp_q.push_back(y[j]);
        load_frame(x, gaps);
        if (hold9) begin
            sample = w9;
            sample_valid = 1'b1;
        end
        // First valid appears in the 13th cycle after the accept edge, i.e. 12 edges later.
        while (!result_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("first_result_latency", lat, N/2*L);
        chk("bf_valid_cycles", bf_seen - bf_base, N/2*L);
        while (frames_out == start && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("frame_complete", 32'(guard < 300), 1);
    endtask

    initial begin
        frame_t      x;
        frame_t      nxt;
        int          base;
        int          guard;
        int          exp_tw [N/2*L] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};

        rst = 1'b1;
        sample = '0;
        sample_valid = 1'b0;
        result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sample_ready", 32'(sample_ready), 1);
        chk("rst_bf_valid", 32'(bf_valid), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_A", a, 0);
        chk("rst_B", b, 0);
        chk("rst_tw", 32'(tw_idx), 0);
        @(posedge clk);
        #1;

        // DC frame
        for (int k = 0; k < N; k++) x[k] = 32'h0001_0000;
        run_frame(x, 1'b0, 1'b0, 1'b0, '0);

        // Ordering with a pass-through butterfly
        for (int k = 0; k < N; k++) x[k] = 32'(k);
        base = bf_seen;
        run_frame(x, 1'b1, 1'b0, 1'b0, '0);
        chk("first_A", a_log[base], 0);
        chk("first_B", b_log[base], 4);
        for (int i = 0; i < N/2*L; i++) chk("tw_idx_seq", 32'(tw_log[base+i]), exp_tw[i]);

        // Backpressure 1,0,0 repeating
        bp_phase = 0;
        bp_mode = 1;
        for (int k = 0; k < N; k++) x[k] = $urandom;
        run_frame(x, 1'b0, 1'b0, 1'b0, '0);
        bp_mode = 0;

        // Input gaps, ninth word held until the next LOAD
        for (int k = 0; k < N; k++) x[k] = $urandom;
        for (int k = 0; k < N; k++) nxt[k] = $urandom;
        run_frame(x, 1'b0, 1'b1, 1'b1, nxt[0]);
        run_frame(nxt, 1'b0, 1'b0, 1'b0, '0);

        // Reset during stage 1
        pass_mode = 1'b0;
        for (int k = 0; k < N; k++) x[k] = $urandom;
        base = bf_seen;
        load_frame(x, 1'b0);
        guard = 0;
        while (bf_seen - base < 5 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        chk("reached_stage1", 32'(guard < 50), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_sample_ready", 32'(sample_ready), 1);
        chk("midrst_bf_valid", 32'(bf_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) x[k] = 32'h0001_0000;
        run_frame(x, 1'b0, 1'b0, 1'b0, '0);

        // Random frames with random backpressure and gaps
        bp_mode = 2;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N; k++) x[k] = $urandom;
            run_frame(x, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
        end
        bp_mode = 0;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
        $fatal(1);
    end
endmodule
